bri_gate_drv: RTL and testbench
===============================

# bri_gate_drv

Dead-time and protection stage between the bridge state machine's `up`/`down` commands and the four H-bridge transmitter switch gates. Converts the diagonal request pair into four gate enables. Guarantees a programmable all-off interval between opposite diagonals and blocks shoot-through on overlapping requests. Latches a fault if one diagonal is held longer than a maximum on-time.

## Interface
Parameters:
- `DEAD_CYC`, default 8: minimum all-gates-off interval in `clk_dds` cycles between one diagonal turning off and any diagonal turning on. Legal range is 1..2^CNT_W-1.
- `MAX_ON`, default 4096: maximum consecutive cycles a diagonal may stay on. Legal range is 2..2^CNT_W.
- `CNT_W`, default 13: width of the gap and on-time counters.

Ports:
- `clk_dds` input 1: system DDS clock; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `up` input 1: request for diagonal A-high/B-low, from the bridge state machine. Registered in the `clk_dds` domain.
- `down` input 1: request for diagonal B-high/A-low.
- `fault_clr` input 1: level; clears a latched fault.
- `q_ah` output 1: gate, bridge leg A high side.
- `q_al` output 1: gate, leg A low side.
- `q_bh` output 1: gate, leg B high side.
- `q_bl` output 1: gate, leg B low side.
- `active` output 1: high while either diagonal is driven.
- `fault` output 1: latched max-on-time fault.
- `overlap_err` output 1: single-cycle flag, `up` and `down` both sampled high.

## Operation
- Decoded request per cycle:
  - UP when `up & ~down`.
  - DN when `down & ~up`.
  - NONE when both inputs are 0 or both are 1.
- Both-high is never forwarded to the gates.
- States: IDLE, DRV_UP, DRV_DN, FAULT. All outputs are registered directly from the state and flag registers, with no combinational decode to the pins.
  - DRV_UP drives `q_ah=q_bl=1`.
  - DRV_DN drives `q_bh=q_al=1`.
  - IDLE and FAULT drive all gates 0.
  - `active` = DRV_UP or DRV_DN.
- `gap_cnt` increments in IDLE and saturates at DEAD_CYC-1. It is cleared to 0 on every entry to IDLE.
- `on_cnt` is cleared on entry to DRV_x and increments each cycle in DRV_x.
- IDLE transitions:
  - To DRV_UP or DRV_DN when the request is UP or DN and `gap_cnt == DEAD_CYC-1`.
  - Otherwise stays in IDLE.
- DRV_x transitions:
  - To IDLE when the request differs from x. This includes NONE and the opposite request; the opposite request therefore always passes through a full IDLE gap.
  - To FAULT when the request still equals x and `on_cnt == MAX_ON-1`.
- FAULT:
  - `fault=1`.
  - To IDLE only on a cycle with `fault_clr=1` and `up=down=0`. `fault` clears on that same edge.
  - `fault_clr` has no effect in other states.
- `overlap_err` is 1 for the cycle after each edge at which `up&down` was sampled, in any state.
- Reset values:
  - State IDLE.
  - `gap_cnt = DEAD_CYC-1`, i.e. ready, so the first request after reset has minimum latency.
  - `on_cnt = 0`.
  - All gates, `active`, `fault` and `overlap_err` are 0.
- Reset mid-drive forces all gates off asynchronously, with no dead-time wait.

## Timing
- Turn-on latency: a request sampled at edge k with the gap satisfied drives the gates from edge k, i.e. 1 cycle after the input changes.
- Turn-off latency: the request drops before edge m; the gates go off at edge m.
- Dead time: if a diagonal goes off at edge m, no gate rises before edge m+DEAD_CYC. The minimum all-off window is exactly DEAD_CYC cycles, achieved when the opposite request is present throughout.
- On-time limit: a diagonal entered at edge k and continuously requested goes off at edge k+MAX_ON, with `fault` high from that edge. The maximum on-width is MAX_ON cycles.
- Fault recovery: after the clear edge, the next drive is possible no earlier than DEAD_CYC cycles later.
- `up`/`down` change only on upstream `clk_4f_en` cycles. This block does not gate on that enable.

## Test plan
Scenarios use DEAD_CYC=4, MAX_ON=16 and CNT_W=5 unless stated otherwise.
1. Reset release with `up=1` from cycle 0 -> `q_ah=q_bl=1` after the first edge; `q_bh=q_al=0`; `active=1`.
2. `up` for 10 cycles, then `down` immediately -> all gates 0 for exactly 4 cycles, then `q_bh=q_al=1`. No cycle ever has `q_ah&q_al` or `q_bh&q_bl` high.
3. `up` and `down` both held high for 3 cycles from IDLE, then `up` only -> gates stay 0 and `overlap_err` is high for 3 cycles. `q_ah` rises 1 cycle after `up`-only is sampled.
4. `up` held for 40 cycles -> gates on for exactly 16 cycles, then off with `fault=1`. `fault_clr=1` while `up=1` has no effect. Dropping `up` with `fault_clr=1` -> `fault=0`; the next `down` drives gates 4 cycles later.
5. `rst` asserted asynchronously mid-DRV_DN -> all outputs 0 immediately, without waiting for a clock edge. After release, `up` gets 1-cycle latency.
6. Default parameters, alternating `up`/`down` with 20-cycle half-periods -> each diagonal is on for 12 cycles with an 8-cycle all-off gap, and `fault` never asserts.

Source files
------------

// File: rtl/bri_gate_drv_if.sv
// Request and gate-enable bundle between the bridge state machine,
// the dead-time/protection stage and the H-bridge gate drivers.
interface bri_gate_drv_if;
    logic up;
    logic down;
    logic fault_clr;
    logic q_ah;
    logic q_al;
    logic q_bh;
    logic q_bl;
    logic active;
    logic fault;
    logic overlap_err;

    modport master (
        output up,
        output down,
        output fault_clr,
        input  q_ah,
        input  q_al,
        input  q_bh,
        input  q_bl,
        input  active,
        input  fault,
        input  overlap_err
    );

    modport slave (
        input  up,
        input  down,
        input  fault_clr,
        output q_ah,
        output q_al,
        output q_bh,
        output q_bl,
        output active,
        output fault,
        output overlap_err
    );
endinterface

// File: rtl/bri_gate_drv.sv
// Dead-time and shoot-through protection between the up/down diagonal requests
// and the four H-bridge gates, with a latched maximum on-time fault.
module bri_gate_drv #(
    parameter int DEAD_CYC = 8,
    parameter int MAX_ON   = 4096,
    parameter int CNT_W    = 13
) (
    input  logic           clk_dds,
    input  logic           rst,
    bri_gate_drv_if.slave  gd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRV_UP = 2'd1,
        DRV_DN = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] gap_cnt_r;
    logic [CNT_W-1:0] gap_cnt_nx_s;
    logic [CNT_W-1:0] on_cnt_r;
    logic [CNT_W-1:0] on_cnt_nx_s;

    logic req_up_s;
    logic req_dn_s;
    logic gap_done_s;
    logic on_last_s;
    logic clr_ok_s;

    logic q_ah_r;
    logic q_al_r;
    logic q_bh_r;
    logic q_bl_r;
    logic active_r;
    logic fault_r;
    logic overlap_err_r;

    // Both-high collapses to no request, so it can never reach the gates.
    assign req_up_s   = gd.up & ~gd.down;
    assign req_dn_s   = gd.down & ~gd.up;
    assign gap_done_s = (gap_cnt_r == GAP_LAST);
    assign on_last_s  = (on_cnt_r == ON_LAST);
    assign clr_ok_s   = gd.fault_clr & ~gd.up & ~gd.down;

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (gap_done_s && req_up_s) begin
                    state_nx_s = DRV_UP;
                end else if (gap_done_s && req_dn_s) begin
                    state_nx_s = DRV_DN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DRV_UP: begin
                if (!req_up_s) begin
                    state_nx_s = IDLE;
                end else if (on_last_s) begin
                    state_nx_s = FAULT;
                end else begin
                    state_nx_s = DRV_UP;
                end
            end
            DRV_DN: begin
                if (!req_dn_s) begin
                    state_nx_s = IDLE;
                end else if (on_last_s) begin
                    state_nx_s = FAULT;
                end else begin
                    state_nx_s = DRV_DN;
                end
            end
            FAULT: begin
                if (clr_ok_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = FAULT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Gap counter restarts on each IDLE entry and saturates once the dead time is met.
    always_comb begin
        gap_cnt_nx_s = gap_cnt_r;
        if ((state_nx_s == IDLE) && (state_r != IDLE)) begin
            gap_cnt_nx_s = CNT_ZERO;
        end else if ((state_r == IDLE) && !gap_done_s) begin
            gap_cnt_nx_s = gap_cnt_r + CNT_ONE;
        end else begin
            gap_cnt_nx_s = gap_cnt_r;
        end
    end

    // On-time counter restarts on diagonal entry and counts while the diagonal is held.
    always_comb begin
        on_cnt_nx_s = on_cnt_r;
        if ((state_nx_s != state_r) && ((state_nx_s == DRV_UP) || (state_nx_s == DRV_DN))) begin
            on_cnt_nx_s = CNT_ZERO;
        end else if ((state_nx_s == state_r) && ((state_r == DRV_UP) || (state_r == DRV_DN))) begin
            on_cnt_nx_s = on_cnt_r + CNT_ONE;
        end else begin
            on_cnt_nx_s = on_cnt_r;
        end
    end

    // State and counter registers; reset leaves the gap satisfied for a fast first drive.
    always_ff @(posedge clk_dds or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            gap_cnt_r <= GAP_LAST;
            on_cnt_r  <= CNT_ZERO;
        end else begin
            state_r   <= state_nx_s;
            gap_cnt_r <= gap_cnt_nx_s;
            on_cnt_r  <= on_cnt_nx_s;
        end
    end

    // Gate and flag registers load alongside the state so pins never see decode glitches.
    always_ff @(posedge clk_dds or posedge rst) begin
        if (rst) begin
            q_ah_r        <= 1'b0;
            q_al_r        <= 1'b0;
            q_bh_r        <= 1'b0;
            q_bl_r        <= 1'b0;
            active_r      <= 1'b0;
            fault_r       <= 1'b0;
            overlap_err_r <= 1'b0;
        end else begin
            q_ah_r        <= (state_nx_s == DRV_UP);
            q_bl_r        <= (state_nx_s == DRV_UP);
            q_bh_r        <= (state_nx_s == DRV_DN);
            q_al_r        <= (state_nx_s == DRV_DN);
            active_r      <= (state_nx_s == DRV_UP) || (state_nx_s == DRV_DN);
            fault_r       <= (state_nx_s == FAULT);
            overlap_err_r <= gd.up & gd.down;
        end
    end

    assign gd.q_ah        = q_ah_r;
    assign gd.q_al        = q_al_r;
    assign gd.q_bh        = q_bh_r;
    assign gd.q_bl        = q_bl_r;
    assign gd.active      = active_r;
    assign gd.fault       = fault_r;
    assign gd.overlap_err = overlap_err_r;

endmodule

// File: tb/tb_bri_gate_drv.sv
// Randomized and directed bench for bri_gate_drv: a small-parameter and a
// default-parameter instance share stimulus and are checked against a timestamp model.
module tb_bri_gate_drv;

    localparam int SD = 4;
    localparam int SM = 16;
    localparam int DD = 8;
    localparam int DM = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bri_gate_drv_if bus_s();
    bri_gate_drv_if bus_d();

    bri_gate_drv #(.DEAD_CYC(SD), .MAX_ON(SM), .CNT_W(5)) dut_s (
        .clk_dds (clk),
        .rst     (rst),
        .gd      (bus_s)
    );

    bri_gate_drv dut_d (
        .clk_dds (clk),
        .rst     (rst),
        .gd      (bus_d)
    );

    // mode: 0 all off, 1 up diagonal, 2 down diagonal, 3 faulted
    typedef struct {
        int mode;
        int last_off;
        int on_start;
        bit flt;
        bit ovl;
    } mdl_t;

    mdl_t ms;
    mdl_t md;
    int   e;
    int   errors = 0;
    int   checks = 0;

    function automatic mdl_t mreset(input int dcyc);
        mdl_t s;
        s.mode     = 0;
        s.last_off = -dcyc;
        s.on_start = 0;
        s.flt      = 1'b0;
        s.ovl      = 1'b0;
        return s;
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input int t, input bit u, input bit d,
                                   input bit fc, input int dcyc, input int mon);
        mdl_t n = s;
        int   req;
        req = (u && !d) ? 1 : ((d && !u) ? 2 : 0);
        case (s.mode)
            0: begin
                if (req != 0 && (t - s.last_off) >= dcyc) begin
                    n.mode     = req;
                    n.on_start = t;
                end
            end
            1, 2: begin
                if (req != s.mode) begin
                    n.mode     = 0;
                    n.last_off = t;
                end else if ((t - s.on_start) >= mon) begin
                    n.mode = 3;
                end
            end
            3: begin
                if (fc && !u && !d) begin
                    n.mode     = 0;
                    n.last_off = t;
                end
            end
            default: n.mode = 0;
        endcase
        n.flt = (n.mode == 3);
        n.ovl = u & d;
        return n;
    endfunction

    // {ah, al, bh, bl, active, fault, overlap_err}
    function automatic logic [6:0] mexp(input mdl_t s);
        return {s.mode == 1, s.mode == 2, s.mode == 2, s.mode == 1,
                (s.mode == 1) || (s.mode == 2), s.flt, s.ovl};
    endfunction

    function automatic logic [6:0] obs_s();
        return {bus_s.q_ah, bus_s.q_al, bus_s.q_bh, bus_s.q_bl,
                bus_s.active, bus_s.fault, bus_s.overlap_err};
    endfunction

    function automatic logic [6:0] obs_d();
        return {bus_d.q_ah, bus_d.q_al, bus_d.q_bh, bus_d.q_bl,
                bus_d.active, bus_d.fault, bus_d.overlap_err};
    endfunction

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit u, input bit d, input bit fc);
        bus_s.up = u;  bus_s.down = d;  bus_s.fault_clr = fc;
        bus_d.up = u;  bus_d.down = d;  bus_d.fault_clr = fc;
    endtask

    task automatic step(input bit u, input bit d, input bit fc);
        drive(u, d, fc);
        @(posedge clk);
        ms = mstep(ms, e, u, d, fc, SD, SM);
        md = mstep(md, e, u, d, fc, DD, DM);
        e++;
        #1;
        check_val("out_s", obs_s(), mexp(ms));
        check_val("out_d", obs_d(), mexp(md));
        check_val("shoot_s", {5'd0, bus_s.q_ah & bus_s.q_al, bus_s.q_bh & bus_s.q_bl}, 7'd0);
        check_val("shoot_d", {5'd0, bus_d.q_ah & bus_d.q_al, bus_d.q_bh & bus_d.q_bl}, 7'd0);
    endtask

    task automatic run(input bit u, input bit d, input bit fc, input int n);
        for (int i = 0; i < n; i++) begin
            step(u, d, fc);
        end
    endtask

    // Called just after an edge: reset must blank the outputs before the next edge.
    task automatic async_reset();
        rst = 1'b1;
        #2;
        check_val("rst_async_s", obs_s(), 7'd0);
        check_val("rst_async_d", obs_d(), 7'd0);
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ms  = mreset(SD);
        md  = mreset(DD);
        e   = 0;
    endtask

    initial begin
        int kind;
        int len;
        bit u;
        bit d;

        drive(1'b1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #2;
        check_val("reset_s", obs_s(), 7'd0);
        check_val("reset_d", obs_d(), 7'd0);
        #9 rst = 1'b0;
        ms = mreset(SD);
        md = mreset(DD);
        e  = 0;

        // up from reset release, then immediate reversal through the dead gap
        run(1'b1, 1'b0, 1'b0, 10);
        run(1'b0, 1'b1, 1'b0, 10);
        run(1'b0, 1'b0, 1'b0, 10);

        // overlapping requests are blocked and flagged
        run(1'b1, 1'b1, 1'b0, 3);
        run(1'b1, 1'b0, 1'b0, 3);
        run(1'b0, 1'b0, 1'b0, 10);

        // max on-time fault, ignored clear while requested, then recovery
        run(1'b1, 1'b0, 1'b0, 40);
        run(1'b1, 1'b0, 1'b1, 3);
        run(1'b0, 1'b0, 1'b0, 2);
        run(1'b0, 1'b0, 1'b1, 1);
        run(1'b0, 1'b1, 1'b0, 8);

        // asynchronous reset mid-drive, then minimum latency again
        async_reset();
        run(1'b1, 1'b0, 1'b0, 2);
        run(1'b0, 1'b1, 1'b0, 5);
        async_reset();
        run(1'b1, 1'b0, 1'b0, 2);
        run(1'b0, 1'b0, 1'b0, 10);

        // alternating half-periods of 20 cycles
        for (int p = 0; p < 6; p++) begin
            run(p[0] == 1'b0, p[0] == 1'b1, 1'b0, 20);
        end
        run(1'b0, 1'b0, 1'b0, 10);

        // randomized request segments
        for (int s = 0; s < 120; s++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 24));
            u    = (kind <= 2) || (kind == 6);
            d    = ((kind >= 3) && (kind <= 5)) || (kind == 6);
            for (int i = 0; i < len; i++) begin
                step(u, d, $urandom_range(0, 3) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
